// File: rtl/axis_i2c_cmd_seq_if.sv
// Single-beat AXI-Stream link from the command sequencer to the I2C master.
interface axis_i2c_cmd_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_i2c_cmd_seq.sv
// Walks a command table and issues each word to the I2C master, handling delays, gaps and end markers.
// Define I2C_CMD_SEQ_RETRY_EN to re-send a NACKed word up to MAX_RETRY extra times before erroring.
module axis_i2c_cmd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_RETRY  = 3,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [AW-1:0]         err_idx,
  output logic [AW-1:0]         tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  axis_i2c_cmd_seq_if.master    m_axis,
  input  logic                  i2c_done,
  input  logic                  i2c_nack
);

  // Counter covers both the longest delay word (255*16) and the configured gap.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (GAP_W > 12) ? GAP_W : 12;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef I2C_CMD_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SEND, WAIT_ACK, GAP, DELAY
  } state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [RW-1:0]         retry_cnt, retry_nxt;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_nxt;
  logic                  done_nxt, error_nxt;
  logic [AW-1:0]         err_idx_nxt;
  logic                  advance;

  // NOTE: reset is sampled synchronously, and all state updates use non-blocking
  // assignments so every register sees pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      retry_cnt <= '0;
      tdata_q   <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_idx   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      tdata_q   <= tdata_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      err_idx   <= err_idx_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    retry_nxt   = retry_cnt;
    tdata_nxt   = tdata_q;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
    err_idx_nxt = err_idx;
    advance     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt     = '0;
          retry_nxt   = '0;
          err_idx_nxt = '0;
          state_nxt   = FETCH;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (tbl_data == 16'hFFFF) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (tbl_data[15:8] == 8'hFE) begin
          if (tbl_data[7:0] == 8'h00) begin
            advance = 1'b1;
          end else begin
            cnt_nxt   = CNT_W'({tbl_data[7:0], 4'h0}) - CNT_W'(1);
            state_nxt = DELAY;
          end
        end else begin
          tdata_nxt = tbl_data;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_axis.tready) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            retry_nxt = '0;
            if (GAP_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              cnt_nxt   = GAP_LOAD;
              state_nxt = GAP;
            end
          end else if (RETRY_EN && (retry_cnt < RW'(MAX_RETRY))) begin
            // Same word is still held in tdata_q, so resend without refetching.
            retry_nxt = retry_cnt + RW'(1);
            state_nxt = SEND;
          end else begin
            error_nxt   = 1'b1;
            err_idx_nxt = idx;
            state_nxt   = IDLE;
          end
        end
      end
      GAP, DELAY: begin
        if (cnt == '0) advance = 1'b1;
        else           cnt_nxt = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase

    // The table never wraps: finishing the last entry ends the sequence.
    if (advance) begin
      if (idx == AW'(DEPTH - 1)) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end else begin
        idx_nxt   = idx + AW'(1);
        state_nxt = FETCH;
      end
    end
  end

  assign busy          = (state != IDLE) || done || error;
  assign tbl_addr      = idx;
  assign m_axis.tvalid = (state == SEND);
  assign m_axis.tlast  = (state == SEND);
  assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_axis_i2c_cmd_seq.sv
// Scoreboard bench for axis_i2c_cmd_seq: table model, I2C responder and beat/outcome checks.
module tb_axis_i2c_cmd_seq;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 4;
`ifdef I2C_CMD_SEQ_RETRY_EN
  localparam int NACK_ATTEMPTS = 4;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] err_idx, tbl_addr;
  logic [15:0]   tbl_data;
  logic          i2c_done = 1'b0;
  logic          i2c_nack = 1'b0;

  axis_i2c_cmd_seq_if #(.DATA_WIDTH(16)) axis ();

  axis_i2c_cmd_seq #(
    .DATA_WIDTH(16), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_idx(err_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_axis(axis), .i2c_done(i2c_done), .i2c_nack(i2c_nack)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [DEPTH];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]   sb [$];
  int            n_cmp = 0, n_bad = 0;
  int            beats, done_cnt, err_cnt, first_rise, gap_meas, start_cyc;
  int            done_cyc = -1000;
  logic [AW-1:0] err_idx_seen;
  logic [15:0]   nack_word = 16'h0000;
  logic          resp_nack;
  logic          prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Beat, outcome and latency observer.
  initial forever begin
    @(negedge clk);
    if (axis.tvalid && !prev_valid) begin
      if (first_rise < 0) first_rise = cyc;
      gap_meas = cyc - done_cyc;
    end
    if (axis.tvalid && axis.tready) begin
      beats++;
      check("tlast", {31'd0, axis.tlast}, 32'd1);
      if (sb.size() > 0) check("beat_data", {16'd0, axis.tdata}, {16'd0, sb.pop_front()});
    end
    if (done) begin
      done_cnt++;
      check("done_err_excl", {31'd0, error}, 32'd0);
      check("busy_at_done", {31'd0, busy}, 32'd1);
    end
    if (error) begin
      err_cnt++;
      err_idx_seen = err_idx;
    end
    prev_valid = axis.tvalid;
  end

  // I2C master model: completion pulse 5 clocks after each accepted beat.
  initial forever begin
    @(negedge clk);
    if (axis.tvalid && axis.tready) begin
      resp_nack = (axis.tdata == nack_word);
      repeat (5) @(posedge clk);
      #1;
      i2c_done = 1'b1;
      i2c_nack = resp_nack;
      done_cyc = cyc;
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
    end
  end

  task automatic load_tbl(input logic [15:0] words [$]);
    for (int i = 0; i < DEPTH; i++) tbl[i] = (i < words.size()) ? words[i] : 16'hFFFF;
  endtask

  task automatic begin_seq();
    beats = 0;
    done_cnt = 0;
    err_cnt = 0;
    first_rise = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_run", {31'd0, busy}, 32'd1);
  endtask

  task automatic end_seq(input int exp_beats, input int exp_done, input int exp_err,
                         input logic [AW-1:0] exp_idx);
    int n = 0;
    while ((done_cnt + err_cnt) == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("done_cnt", done_cnt, exp_done);
    check("err_cnt", err_cnt, exp_err);
    if (exp_err != 0) begin
      check("err_idx_pulse", {28'd0, err_idx_seen}, {28'd0, exp_idx});
      check("err_idx_hold", {28'd0, err_idx}, {28'd0, exp_idx});
    end
    check("busy_after", {31'd0, busy}, 32'd0);
    check("beat_count", beats, exp_beats);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_tvalid"}, {31'd0, axis.tvalid}, 32'd0);
    check({tag, "_tlast"}, {31'd0, axis.tlast}, 32'd0);
    check({tag, "_tdata"}, {16'd0, axis.tdata}, 32'd0);
    check({tag, "_tbl_addr"}, {28'd0, tbl_addr}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words [$];
    int n;
    axis.tready = 1'b1;
    load_tbl('{16'hFFFF});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    check("por_err_idx", {28'd0, err_idx}, 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Two commands and an end marker.
    load_tbl('{16'h1234, 16'h5678, 16'hFFFF});
    sb.push_back(16'h1234);
    sb.push_back(16'h5678);
    begin_seq();
    end_seq(2, 1, 0, '0);
    check("start_latency", first_rise - start_cyc, 3);
    check("gap_len", gap_meas, GAP + 3);

    // Back-pressure: tready low for 10 cycles while the first word is offered.
    load_tbl('{16'h1234, 16'hFFFF});
    sb.push_back(16'h1234);
    axis.tready = 1'b0;
    begin_seq();
    n = 0;
    while (!axis.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {31'd0, axis.tvalid}, 32'd1);
      check("stall_data", {16'd0, axis.tdata}, 32'h1234);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axis.tready = 1'b1;
    end_seq(1, 1, 0, '0);

    // Delay word of 32 clocks, then a zero-length delay that issues nothing.
    load_tbl('{16'hFE02, 16'h1111, 16'hFE00, 16'h2222, 16'hFFFF});
    sb.push_back(16'h1111);
    sb.push_back(16'h2222);
    begin_seq();
    end_seq(2, 1, 0, '0);
    check("delay_latency", first_rise - start_cyc, 3 + 32 + 2);

    // NACK on entry 1.
    load_tbl('{16'h1001, 16'hA5A5, 16'h1003, 16'hFFFF});
    nack_word = 16'hA5A5;
    sb.push_back(16'h1001);
    for (int i = 0; i < NACK_ATTEMPTS; i++) sb.push_back(16'hA5A5);
    begin_seq();
    end_seq(1 + NACK_ATTEMPTS, 0, 1, AW'(1));
    nack_word = 16'h0000;

    // Reset while waiting for the first ACK.
    load_tbl('{16'h4444, 16'h5555, 16'hFFFF});
    sb.push_back(16'h4444);
    begin_seq();
    n = 0;
    while (beats < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_beats", beats, 1);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (12) @(negedge clk);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    sb.delete();

    // Restart after reset begins at entry 0.
    sb.push_back(16'h4444);
    sb.push_back(16'h5555);
    begin_seq();
    end_seq(2, 1, 0, '0);
    check("restart_latency", first_rise - start_cyc, 3);

    // Full table without end marker, with a stray start mid-sequence.
    words.delete();
    for (int i = 0; i < DEPTH; i++) begin
      words.push_back(16'h0100 + 16'(i));
      sb.push_back(16'h0100 + 16'(i));
    end
    load_tbl(words);
    begin_seq();
    repeat (30) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    end_seq(DEPTH, 1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
